// File: rtl/regfile_writeback.sv
// regfile_writeback: writeback arbiter merging ALU results with a load queue onto the register-file write port.
// Ports: clk, reset (async, active-high);
//   alu_valid_in/alu_addr_in/alu_data_in  single-cycle ALU result, no backpressure;
//   ld_valid_in/ld_ready_out/ld_addr_in/ld_data_in  load result handshake into the load queue;
//   alu_stall_out  asks issue to send no ALU result next cycle so the queue can drain;
//   rf_write_out/rf_addr_out/rf_data_out  registered register-file write port;
//   rd_addr0_in/rd_addr1_in, rf_rdata0_in/rf_rdata1_in, rd_data0_out/rd_data1_out  read ports with write forwarding;
//   debugen_in  enables a per-write simulation trace.
module regfile_writeback #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid_in,
  input  logic [ADDR_WIDTH-1:0] alu_addr_in,
  input  logic [DATA_WIDTH-1:0] alu_data_in,
  input  logic                  ld_valid_in,
  output logic                  ld_ready_out,
  input  logic [ADDR_WIDTH-1:0] ld_addr_in,
  input  logic [DATA_WIDTH-1:0] ld_data_in,
  output logic                  alu_stall_out,
  output logic                  rf_write_out,
  output logic [ADDR_WIDTH-1:0] rf_addr_out,
  output logic [DATA_WIDTH-1:0] rf_data_out,
  input  logic [ADDR_WIDTH-1:0] rd_addr0_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr1_in,
  input  logic [DATA_WIDTH-1:0] rf_rdata0_in,
  input  logic [DATA_WIDTH-1:0] rf_rdata1_in,
  output logic [DATA_WIDTH-1:0] rd_data0_out,
  output logic [DATA_WIDTH-1:0] rd_data1_out,
  input  logic                  debugen_in
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL = CW'(LQ_DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [ADDR_WIDTH-1:0] q_addr [LQ_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [LQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  logic rf_src_alu;
  logic empty, alu_win, enq, pop, starve_hit;
  logic [SW-1:0] starve_inc;
  // Ready and pop both look only at the registered count, so a full queue
  // never accepts in a dequeue cycle and a fresh entry cannot pop the same cycle.
  assign empty        = count == '0;
  assign ld_ready_out = count != FULL;
  assign alu_win      = alu_valid_in && alu_addr_in != '0;
  assign enq          = ld_valid_in && ld_ready_out && ld_addr_in != '0;
  assign pop          = !alu_win && !empty;
  assign starve_inc   = starve + 1'b1;
  assign starve_hit   = alu_win && !empty && starve_inc == SMAX;
  assign rd_data0_out = (rf_write_out && rf_addr_out == rd_addr0_in) ? rf_data_out : rf_rdata0_in;
  assign rd_data1_out = (rf_write_out && rf_addr_out == rd_addr1_in) ? rf_data_out : rf_rdata1_in;
  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[wr_ptr] <= ld_addr_in;
      q_data[wr_ptr] <= ld_data_in;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      starve        <= '0;
      alu_stall_out <= 1'b0;
      rf_write_out  <= 1'b0;
      rf_addr_out   <= '0;
      rf_data_out   <= '0;
      rf_src_alu    <= 1'b0;
    end else begin
      wr_ptr        <= enq ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr        <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count         <= count + CW'(enq) - CW'(pop);
      starve        <= (pop || empty || starve_hit) ? '0 : alu_win ? starve_inc : starve;
      alu_stall_out <= starve_hit;
      rf_write_out  <= alu_win || pop;
      rf_addr_out   <= alu_win ? alu_addr_in : pop ? q_addr[rd_ptr] : '0;
      rf_data_out   <= alu_win ? alu_data_in : pop ? q_data[rd_ptr] : '0;
      rf_src_alu    <= alu_win;
    end
  end
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && debugen_in && rf_write_out)
      $write("[%0t] wb x%0d = 0x%0h (%s)\n", $time, rf_addr_out, rf_data_out, rf_src_alu ? "ALU" : "LQ");
  end
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed vector and sequence checks for regfile_writeback.
module tb_regfile_writeback;
  logic clk = 1'b0;
  logic reset;
  logic alu_valid_in, ld_valid_in, ld_ready_out, alu_stall_out, rf_write_out, debugen_in;
  logic [7:0] alu_addr_in, ld_addr_in, rf_addr_out, rd_addr0_in, rd_addr1_in;
  logic [31:0] alu_data_in, ld_data_in, rf_data_out, rf_rdata0_in, rf_rdata1_in, rd_data0_out, rd_data1_out;
  int n_cmp = 0, n_err = 0;
  regfile_writeback dut (
    .clk(clk), .reset(reset),
    .alu_valid_in(alu_valid_in), .alu_addr_in(alu_addr_in), .alu_data_in(alu_data_in),
    .ld_valid_in(ld_valid_in), .ld_ready_out(ld_ready_out), .ld_addr_in(ld_addr_in), .ld_data_in(ld_data_in),
    .alu_stall_out(alu_stall_out),
    .rf_write_out(rf_write_out), .rf_addr_out(rf_addr_out), .rf_data_out(rf_data_out),
    .rd_addr0_in(rd_addr0_in), .rd_addr1_in(rd_addr1_in),
    .rf_rdata0_in(rf_rdata0_in), .rf_rdata1_in(rf_rdata1_in),
    .rd_data0_out(rd_data0_out), .rd_data1_out(rd_data1_out),
    .debugen_in(debugen_in)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic av; logic [7:0] aa; logic [31:0] ad;
    logic lv; logic [7:0] la; logic [31:0] ld;
    logic [7:0] r0a; logic [31:0] r0d; logic [7:0] r1a; logic [31:0] r1d;
    logic w; logic [7:0] wa; logic [31:0] wd; logic rdy; logic [31:0] e0; logic [31:0] e1;
  } vec_t;
  vec_t v [10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic av, input logic [7:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [7:0] la, input logic [31:0] ld);
    alu_valid_in = av; alu_addr_in = aa; alu_data_in = ad;
    ld_valid_in = lv; ld_addr_in = la; ld_data_in = ld;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, e, cyc;
    logic acc;
    v[0] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,   8'd1, 32'h55, 8'd2, 32'h66, 1'b0, 8'd0, 32'h0,   1'b1, 32'h55,  32'h66};
    v[1] = '{1'b1, 8'd5, 32'h11, 1'b0, 8'd0, 32'h0,   8'd5, 32'hAA, 8'd3, 32'hBB, 1'b1, 8'd5, 32'h11,  1'b1, 32'h11,  32'hBB};
    v[2] = '{1'b1, 8'd0, 32'h99, 1'b0, 8'd0, 32'h0,   8'd5, 32'hAA, 8'd5, 32'hBB, 1'b0, 8'd0, 32'h0,   1'b1, 32'hAA,  32'hBB};
    v[3] = '{1'b0, 8'd0, 32'h0,  1'b1, 8'd9, 32'h300, 8'd9, 32'hC1, 8'd9, 32'hC2, 1'b0, 8'd0, 32'h0,   1'b1, 32'hC1,  32'hC2};
    v[4] = '{1'b1, 8'd0, 32'h99, 1'b0, 8'd0, 32'h0,   8'd9, 32'hC1, 8'd9, 32'hC2, 1'b1, 8'd9, 32'h300, 1'b1, 32'h300, 32'h300};
    v[5] = '{1'b0, 8'd0, 32'h0,  1'b1, 8'd0, 32'h777, 8'd0, 32'h0,  8'd0, 32'h0,  1'b0, 8'd0, 32'h0,   1'b1, 32'h0,   32'h0};
    v[6] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,   8'd0, 32'h0,  8'd0, 32'h0,  1'b0, 8'd0, 32'h0,   1'b1, 32'h0,   32'h0};
    v[7] = '{1'b1, 8'd7, 32'h1,  1'b1, 8'd7, 32'h2,   8'd7, 32'h5,  8'd7, 32'h6,  1'b1, 8'd7, 32'h1,   1'b1, 32'h1,   32'h1};
    v[8] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,   8'd7, 32'h5,  8'd7, 32'h6,  1'b1, 8'd7, 32'h2,   1'b1, 32'h2,   32'h2};
    v[9] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 32'h0,   8'd7, 32'h5,  8'd7, 32'h6,  1'b0, 8'd0, 32'h0,   1'b1, 32'h5,   32'h6};
    debugen_in = 1'b0;
    reset = 1'b1;
    drive(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 32'h0);
    rd_addr0_in = '0; rd_addr1_in = '0; rf_rdata0_in = '0; rf_rdata1_in = '0;
    tick();
    tick();
    chk("reset rf_write", rf_write_out, 0);
    chk("reset rf_addr", rf_addr_out, 0);
    chk("reset rf_data", rf_data_out, 0);
    chk("reset stall", alu_stall_out, 0);
    chk("reset ready", ld_ready_out, 1);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(v[i].av, v[i].aa, v[i].ad, v[i].lv, v[i].la, v[i].ld);
      rd_addr0_in = v[i].r0a; rf_rdata0_in = v[i].r0d;
      rd_addr1_in = v[i].r1a; rf_rdata1_in = v[i].r1d;
      tick();
      chk($sformatf("vec%0d rf_write", i), rf_write_out, v[i].w);
      if (v[i].w) begin
        chk($sformatf("vec%0d rf_addr", i), rf_addr_out, v[i].wa);
        chk($sformatf("vec%0d rf_data", i), rf_data_out, v[i].wd);
      end
      chk($sformatf("vec%0d ready", i), ld_ready_out, v[i].rdy);
      chk($sformatf("vec%0d stall", i), alu_stall_out, 0);
      chk($sformatf("vec%0d rd_data0", i), rd_data0_out, v[i].e0);
      chk($sformatf("vec%0d rd_data1", i), rd_data1_out, v[i].e1);
    end
    rd_addr0_in = '0; rd_addr1_in = '0; rf_rdata0_in = '0; rf_rdata1_in = '0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(10 + i), 32'h50 + i, 1'b1, 8'(1 + i), 32'h100 + i);
      chk($sformatf("starve ready pre %0d", i), ld_ready_out, 1);
      tick();
      chk($sformatf("starve alu addr %0d", i), rf_addr_out, 10 + i);
      chk($sformatf("starve stall %0d", i), alu_stall_out, 0);
      chk($sformatf("starve ready post %0d", i), ld_ready_out, i < 3);
    end
    drive(1'b1, 8'd20, 32'h60, 1'b0, 8'd0, 32'h0);
    tick();
    chk("starve stall hit", alu_stall_out, 1);
    chk("starve 5th alu addr", rf_addr_out, 20);
    drive(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 32'h0);
    tick();
    chk("stall slot rf_write", rf_write_out, 1);
    chk("stall slot rf_addr", rf_addr_out, 1);
    chk("stall slot rf_data", rf_data_out, 32'h100);
    chk("stall one cycle", alu_stall_out, 0);
    chk("stall slot ready", ld_ready_out, 1);
    for (int j = 1; j < 4; j++) begin
      tick();
      chk($sformatf("drain addr %0d", j), rf_addr_out, 1 + j);
      chk($sformatf("drain data %0d", j), rf_data_out, 32'h100 + j);
    end
    tick();
    chk("drain idle", rf_write_out, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(30 + i), 32'h70 + i, 1'b1, 8'(32 + i), 32'h200 + i);
      tick();
      chk($sformatf("fill alu addr %0d", i), rf_addr_out, 30 + i);
    end
    drive(1'b0, 8'd0, 32'h0, 1'b1, 8'd36, 32'h204);
    chk("full ready", ld_ready_out, 0);
    tick();
    chk("full pop write", rf_write_out, 1);
    chk("full pop addr", rf_addr_out, 32);
    chk("full pop data", rf_data_out, 32'h200);
    chk("ready back", ld_ready_out, 1);
    k = 4; e = 1; cyc = 0;
    while (e < 8 && cyc < 40) begin
      drive(1'b0, 8'd0, 32'h0, k < 8, 8'(32 + k), 32'h200 + k);
      acc = ld_valid_in && ld_ready_out;
      tick();
      cyc++;
      if (acc) k++;
      chk($sformatf("wrap pop %0d", e), rf_write_out, 1);
      if (rf_write_out) begin
        chk($sformatf("wrap addr %0d", e), rf_addr_out, 32 + e);
        chk($sformatf("wrap data %0d", e), rf_data_out, 32'h200 + e);
        e++;
      end
    end
    chk("wrap loads accepted", k, 8);
    chk("wrap loads written", e, 8);
    drive(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 32'h0);
    tick();
    chk("wrap idle", rf_write_out, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(40 + i), 32'h90 + i, 1'b1, 8'(1 + i), 32'h400 + i);
      tick();
    end
    drive(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset rf_write", rf_write_out, 0);
    chk("midreset ready", ld_ready_out, 1);
    chk("midreset stall", alu_stall_out, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("midreset no write %0d", i), rf_write_out, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
